// File: rtl/riscv_pkg.sv
// Shared integer register-file types and defaults for the ID stage.
// Pure declarations: no latency, no flow control.
package riscv_pkg;

    localparam int REG_ADDR_WIDTH_DFLT = 5;
    localparam int DATA_WIDTH_DFLT     = 32;

    localparam logic [REG_ADDR_WIDTH_DFLT-1:0] X0 = '0;

    typedef logic [REG_ADDR_WIDTH_DFLT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: bits update one edge after issue/writeback; busy lookup is combinational.
// Every port serviced every cycle; no stalls, no backpressure.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [NUM_WR-1:0]                wr_en_i,
    input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                             issue_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]        issue_rd_i,
    output logic [NUM_RD-1:0]                rd_busy_o,
    output logic [2**REG_ADDR_WIDTH-1:0]     pending_o
);

    localparam int ENTRIES = 2**REG_ADDR_WIDTH;

    logic [ENTRIES-1:0] pending_q;
    logic [ENTRIES-1:0] pending_d;
    logic [ENTRIES-1:0] wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) begin
                wr_hit[wr_addr_i[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = 1'b1;
            end
        end
    end

    // Issue is applied after the clear so a new producer keeps the bit set.
    always_comb begin
        pending_d = pending_q & ~wr_hit;
        if (issue_valid_i) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_o[k] = pending_q[rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]]
                         & ~wr_hit[rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/multiport_regfile.sv
// Multi-port integer register file, x0 = 0, write-first bypass, integrated scoreboard.
// Read latency 0 (READ_REG=0) or 1 (READ_REG=1); busy is always same-cycle; no backpressure.
module multiport_regfile
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DFLT,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 1,
    parameter int READ_REG       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data_o,
    output logic [NUM_RD-1:0]                rd_busy_o,
    input  logic [NUM_WR-1:0]                wr_en_i,
    input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0]     wr_data_i,
    input  logic                             issue_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]        issue_rd_i,
    output logic [2**REG_ADDR_WIDTH-1:0]     pending_o
);

    localparam int ENTRIES = 2**REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(X0);

    logic [DATA_WIDTH-1:0]        regs_q [ENTRIES];
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && wr_addr_i[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != ZERO_ADDR) begin
                    regs_q[wr_addr_i[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] <= wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && wr_addr_i[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
                                  == rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) begin
                    rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == ZERO_ADDR) begin
                rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end
            assign rd_data_o = rd_data_q;
        end else begin : g_rd_comb
            assign rd_data_o = rd_data_d;
        end
    endgenerate

    regfile_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_RD         (NUM_RD),
        .NUM_WR         (NUM_WR)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .rd_addr_i     (rd_addr_i),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .rd_busy_o     (rd_busy_o),
        .pending_o     (pending_o)
    );

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: a combinational-read and a registered-read instance share stimulus.
// Expected values come from a behavioural model and are queued per cycle.
module tb_multiport_regfile;
    import riscv_pkg::*;

    typedef struct {
        logic        r;
        reg_addr_t   ra0, ra1;
        logic [1:0]  we;
        reg_addr_t   wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iv;
        reg_addr_t   ir;
    } stim_t;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  busy;
        logic [31:0] pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [63:0] rd_data0, rd_data1;
    logic [1:0]  busy0, busy1;
    logic [31:0] pend0, pend1;

    logic [31:0] mreg [32];
    logic [31:0] mpend;
    logic [31:0] mhit;
    exp_t        q0[$];
    exp_t        q1[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multiport_regfile #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2), .READ_REG(0)) dut0 (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_busy_o(busy0),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .pending_o(pend0)
    );

    multiport_regfile #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2), .READ_REG(1)) dut1 (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_busy_o(busy1),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .pending_o(pend1)
    );

    // Reference model state, advanced at each rising edge from the driven inputs.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            mpend = '0;
        end else begin
            mhit = '0;
            if (wr_en[0] && wr_addr[4:0] != 5'd0) begin
                mreg[wr_addr[4:0]] = wr_data[31:0];
                mhit[wr_addr[4:0]] = 1'b1;
            end
            if (wr_en[1] && wr_addr[9:5] != 5'd0) begin
                mreg[wr_addr[9:5]] = wr_data[63:32];
                mhit[wr_addr[9:5]] = 1'b1;
            end
            mpend = mpend & ~mhit;
            if (issue_valid && issue_rd != 5'd0) mpend[issue_rd] = 1'b1;
        end
    end

    task automatic drive(input stim_t s);
        exp_t        e;
        logic [4:0]  a;
        logic [31:0] v;
        logic        hit;
        rst         = s.r;
        rd_addr     = {s.ra1, s.ra0};
        wr_en       = s.we;
        wr_addr     = {s.wa1, s.wa0};
        wr_data     = {s.wd1, s.wd0};
        issue_valid = s.iv;
        issue_rd    = s.ir;
        e.pend = mpend;
        e.rd   = '0;
        e.busy = '0;
        for (int k = 0; k < 2; k++) begin
            a   = (k == 0) ? s.ra0 : s.ra1;
            v   = mreg[a];
            hit = 1'b0;
            if (s.we[0] && s.wa0 == a) begin v = s.wd0; hit = 1'b1; end
            if (s.we[1] && s.wa1 == a) begin v = s.wd1; hit = 1'b1; end
            if (a == 5'd0) v = '0;
            e.rd[k*32 +: 32] = v;
            e.busy[k] = (a != 5'd0) && mpend[a] && !hit;
        end
        q0.push_back(e);
        if (s.r) e.rd = '0;
        q1.push_back(e);
    endtask

    function automatic stim_t st(logic r, reg_addr_t ra0, reg_addr_t ra1, logic [1:0] we,
                                 reg_addr_t wa0, logic [31:0] wd0, reg_addr_t wa1, logic [31:0] wd1,
                                 logic iv, reg_addr_t ir);
        stim_t s;
        s.r = r; s.ra0 = ra0; s.ra1 = ra1; s.we = we;
        s.wa0 = wa0; s.wd0 = wd0; s.wa1 = wa1; s.wd1 = wd1;
        s.iv = iv; s.ir = ir;
        return s;
    endfunction

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 19; i++) begin
            if (i == 0)       drive(st(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
            else if (i <= 16) drive(st(0, 5'(2*(i-1)), 5'(2*(i-1)+1), 2'b00, 0, 0, 0, 0, 0, 0));
            else if (i == 17) drive(st(0, 0, 0, 2'b01, 0, 32'hDEADBEEF, 0, 0, 0, 0));
            else              drive(st(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = q0.pop_front();
            n_vec++;
            if (rd_data0 !== e.rd || rd_data0 !== 64'd0) begin
                n_err++; $display("FAIL reset_rd step %0d: got %h want %h", i, rd_data0, e.rd);
            end
            n_vec++;
            if (pend0 !== e.pend || pend1 !== 32'd0) begin
                n_err++; $display("FAIL reset_pend step %0d: got %h/%h want %h", i, pend0, pend1, e.pend);
            end
            @(posedge clk); #1;
            e = q1.pop_front();
            n_vec++;
            if (rd_data1 !== e.rd) begin
                n_err++; $display("FAIL reset_rdreg step %0d: got %h want %h", i, rd_data1, e.rd);
            end
        end
    endtask

    task automatic test_write_bypass();
        exp_t  e;
        stim_t s [3];
        s[0] = st(0, 5, 0, 2'b01, 5, 32'h12345678, 0, 0, 0, 0);
        s[1] = st(0, 5, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        s[2] = st(0, 6, 5, 2'b10, 0, 0, 6, 32'hCAFEF00D, 0, 0);
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            e = q0.pop_front();
            n_vec++;
            if (rd_data0 !== e.rd || busy0 !== e.busy) begin
                n_err++; $display("FAIL bypass_comb step %0d: got %h/%b want %h/%b", i, rd_data0, busy0, e.rd, e.busy);
            end
            n_vec++;
            if ((i == 0 && rd_data0[31:0] !== 32'h12345678) || (i == 1 && rd_data0 !== {2{32'h12345678}})) begin
                n_err++; $display("FAIL bypass_x5 step %0d: got %h want 12345678", i, rd_data0);
            end
            @(posedge clk); #1;
            e = q1.pop_front();
            n_vec++;
            if (rd_data1 !== e.rd) begin
                n_err++; $display("FAIL bypass_reg step %0d: got %h want %h", i, rd_data1, e.rd);
            end
        end
    endtask

    task automatic test_collision();
        exp_t  e;
        stim_t s [3];
        s[0] = st(0, 7, 7, 2'b11, 7, 32'h1, 7, 32'h2, 0, 0);
        s[1] = st(0, 7, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        s[2] = st(0, 7, 8, 2'b11, 8, 32'h3, 8, 32'h4, 0, 0);
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            e = q0.pop_front();
            n_vec++;
            if (rd_data0 !== e.rd || (i == 1 && rd_data0 !== {2{32'h2}})) begin
                n_err++; $display("FAIL collision_comb step %0d: got %h want %h", i, rd_data0, e.rd);
            end
            @(posedge clk); #1;
            e = q1.pop_front();
            n_vec++;
            if (rd_data1 !== e.rd) begin
                n_err++; $display("FAIL collision_reg step %0d: got %h want %h", i, rd_data1, e.rd);
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t  e;
        stim_t s [5];
        s[0] = st(0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 3);
        s[1] = st(0, 3, 3, 2'b00, 0, 0, 0, 0, 0, 0);
        s[2] = st(0, 3, 3, 2'b01, 3, 32'hAA, 0, 0, 0, 0);
        s[3] = st(0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        s[4] = st(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            e = q0.pop_front();
            n_vec++;
            if (busy0 !== e.busy || busy1 !== e.busy || pend0 !== e.pend || pend1 !== e.pend) begin
                n_err++; $display("FAIL sb_busy step %0d: got %b/%h want %b/%h", i, busy0, pend0, e.busy, e.pend);
            end
            n_vec++;
            if ((i == 1 && (busy0 !== 2'b11 || pend0[3] !== 1'b1)) ||
                (i == 2 && (busy0 !== 2'b00 || rd_data0 !== {2{32'hAA}})) ||
                (i >= 3 && pend0 !== 32'd0)) begin
                n_err++; $display("FAIL sb_x3 step %0d: got %b/%h/%h", i, busy0, pend0, rd_data0);
            end
            @(posedge clk); #1;
            e = q1.pop_front();
            n_vec++;
            if (rd_data1 !== e.rd) begin
                n_err++; $display("FAIL sb_reg step %0d: got %h want %h", i, rd_data1, e.rd);
            end
        end
    endtask

    task automatic test_set_beats_clear();
        exp_t  e;
        stim_t s [5];
        s[0] = st(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 9);
        s[1] = st(0, 9, 9, 2'b01, 9, 32'h55, 0, 0, 1, 9);
        s[2] = st(0, 9, 9, 2'b00, 0, 0, 0, 0, 0, 0);
        s[3] = st(0, 9, 0, 2'b10, 0, 0, 9, 32'h66, 0, 0);
        s[4] = st(0, 9, 9, 2'b00, 0, 0, 0, 0, 0, 0);
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            e = q0.pop_front();
            n_vec++;
            if (rd_data0 !== e.rd || busy0 !== e.busy || pend0 !== e.pend) begin
                n_err++; $display("FAIL sbc_comb step %0d: got %h/%b/%h want %h/%b/%h",
                                  i, rd_data0, busy0, pend0, e.rd, e.busy, e.pend);
            end
            n_vec++;
            if (i == 2 && (busy0 !== 2'b11 || pend0[9] !== 1'b1 || rd_data0 !== {2{32'h55}})) begin
                n_err++; $display("FAIL sbc_x9: got %b/%h/%h want 11/pending/55", busy0, pend0, rd_data0);
            end
            @(posedge clk); #1;
            e = q1.pop_front();
            n_vec++;
            if (rd_data1 !== e.rd) begin
                n_err++; $display("FAIL sbc_reg step %0d: got %h want %h", i, rd_data1, e.rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t  e;
        stim_t s [4];
        s[0] = st(0, 0, 0, 2'b01, 4, 32'h77, 0, 0, 1, 4);
        s[1] = st(0, 4, 4, 2'b00, 0, 0, 0, 0, 0, 0);
        s[2] = st(1, 4, 4, 2'b01, 4, 32'h99, 0, 0, 1, 4);
        s[3] = st(0, 4, 4, 2'b00, 0, 0, 0, 0, 0, 0);
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            e = q0.pop_front();
            n_vec++;
            if (rd_data0 !== e.rd || busy0 !== e.busy || pend0 !== e.pend) begin
                n_err++; $display("FAIL rstmid_comb step %0d: got %h/%b/%h want %h/%b/%h",
                                  i, rd_data0, busy0, pend0, e.rd, e.busy, e.pend);
            end
            n_vec++;
            if (i == 3 && (pend0 !== 32'd0 || rd_data0 !== 64'd0)) begin
                n_err++; $display("FAIL rstmid_x4: got %h/%h want 0/0", pend0, rd_data0);
            end
            @(posedge clk); #1;
            e = q1.pop_front();
            n_vec++;
            if (rd_data1 !== e.rd) begin
                n_err++; $display("FAIL rstmid_reg step %0d: got %h want %h", i, rd_data1, e.rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        stim_t s;
        for (int i = 0; i < 400; i++) begin
            s = st($urandom_range(63) == 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
                   2'($urandom_range(3)), 5'($urandom_range(7)), $urandom,
                   5'($urandom_range(7)), $urandom, 1'($urandom_range(1)), 5'($urandom_range(7)));
            drive(s);
            @(negedge clk);
            e = q0.pop_front();
            n_vec++;
            if (rd_data0 !== e.rd || busy0 !== e.busy || busy1 !== e.busy ||
                pend0 !== e.pend || pend1 !== e.pend) begin
                n_err++; $display("FAIL b2b_comb cycle %0d: got %h/%b/%h want %h/%b/%h",
                                  i, rd_data0, busy0, pend0, e.rd, e.busy, e.pend);
            end
            @(posedge clk); #1;
            e = q1.pop_front();
            n_vec++;
            if (rd_data1 !== e.rd) begin
                n_err++; $display("FAIL b2b_reg cycle %0d: got %h want %h", i, rd_data1, e.rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mpend       = '0;
        mhit        = '0;
        rst         = 1'b1;
        rd_addr     = '0;
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        @(posedge clk); #1;
        test_reset();
        test_write_bypass();
        test_collision();
        test_scoreboard();
        test_set_beats_clear();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
